// File: rtl/uart_fifo_bridge.sv
// Host-side front end for the UART controller: register port, TX/RX FIFOs,
// single-request TX sequencer and edge-detected RX capture.
module uart_fifo_bridge #(
   parameter int  FIFO_DEPTH = 8,
   localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
   input  logic       s_clk_i,
   input  logic       s_resetn_i,
   input  logic       s_req_i,
   input  logic       s_we_i,
   input  logic [1:0] s_addr_i,
   input  logic [7:0] s_wdata_i,
   output logic [7:0] s_rdata_o,
   output logic       s_ack_o,
   output logic       s_irq_o,
   output logic       s_uart_request_o,
   output logic [7:0] s_uart_data_o,
   input  logic [7:0] s_uart_data_i,
   input  logic       s_uart_ready_i,
   input  logic       s_uart_busy_i
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GUARD = 2'd2,
      ST_WAIT  = 2'd3
   } tx_state_t;

   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W+1)'(0);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

   tx_state_t        state_r, state_s;
   logic [7:0]       tx_mem_r [FIFO_DEPTH];
   logic [7:0]       rx_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] tx_wr_ptr_r, tx_rd_ptr_r, rx_wr_ptr_r, rx_rd_ptr_r;
   logic [PTR_W:0]   tx_cnt_r, rx_cnt_r, tx_cnt_s, rx_cnt_s;
   logic             tx_drop_r, rx_ovr_r, tx_drop_s, rx_ovr_s;
   logic             ready_d_r;
   logic [7:0]       rdata_r, rdata_s, uart_data_r;
   logic             ack_r, irq_r, request_r;

   logic             acc_data_s, acc_stat_s;
   logic             tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
   logic             tx_push_s, tx_pop_s, rx_edge_s, rx_push_s, rx_pop_s;
   logic [7:0]       status_s;

   assign acc_data_s = s_req_i & (s_addr_i == 2'b00);
   assign acc_stat_s = s_req_i & (s_addr_i == 2'b01);
   assign tx_empty_s = (tx_cnt_r == CNT_ZERO);
   assign tx_full_s  = (tx_cnt_r == FULL_CNT);
   assign rx_empty_s = (rx_cnt_r == CNT_ZERO);
   assign rx_full_s  = (rx_cnt_r == FULL_CNT);

   // A full TX FIFO drops the write even if the sequencer pops on the same edge.
   assign tx_push_s = acc_data_s & s_we_i & ~tx_full_s;
   assign tx_pop_s  = (state_r == ST_IDLE) & ~tx_empty_s & ~s_uart_busy_i;
   assign rx_edge_s = s_uart_ready_i & ~ready_d_r;
   assign rx_pop_s  = acc_data_s & ~s_we_i & ~rx_empty_s;
   assign rx_push_s = rx_edge_s & (~rx_full_s | rx_pop_s);

   assign status_s = {1'b0, (state_r != ST_IDLE), tx_drop_r, rx_ovr_r,
                      rx_full_s, rx_empty_s, tx_full_s, tx_empty_s};

   // TX sequencer next state.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (tx_pop_s) state_s = ST_ISSUE;
            else          state_s = ST_IDLE;
         end
         ST_ISSUE: state_s = ST_GUARD;
         ST_GUARD: state_s = ST_WAIT;
         ST_WAIT: begin
            if (!s_uart_busy_i) state_s = ST_IDLE;
            else                state_s = ST_WAIT;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // FIFO occupancy and sticky flag next values (set wins over clear).
   always_comb begin
      tx_cnt_s  = tx_cnt_r;
      rx_cnt_s  = rx_cnt_r;
      tx_drop_s = tx_drop_r;
      rx_ovr_s  = rx_ovr_r;
      if (tx_push_s && !tx_pop_s)      tx_cnt_s = tx_cnt_r + CNT_ONE;
      else if (!tx_push_s && tx_pop_s) tx_cnt_s = tx_cnt_r - CNT_ONE;
      else                             tx_cnt_s = tx_cnt_r;
      if (rx_push_s && !rx_pop_s)      rx_cnt_s = rx_cnt_r + CNT_ONE;
      else if (!rx_push_s && rx_pop_s) rx_cnt_s = rx_cnt_r - CNT_ONE;
      else                             rx_cnt_s = rx_cnt_r;
      if (acc_data_s && s_we_i && tx_full_s)              tx_drop_s = 1'b1;
      else if (acc_stat_s && s_we_i && s_wdata_i[5])      tx_drop_s = 1'b0;
      else                                                tx_drop_s = tx_drop_r;
      if (rx_edge_s && rx_full_s && !rx_pop_s)            rx_ovr_s = 1'b1;
      else if (acc_stat_s && s_we_i && s_wdata_i[4])      rx_ovr_s = 1'b0;
      else                                                rx_ovr_s = rx_ovr_r;
   end

   // Read data mux; value holds between reads.
   always_comb begin
      rdata_s = rdata_r;
      if (s_req_i && !s_we_i) begin
         case (s_addr_i)
            2'b00:   rdata_s = rx_empty_s ? 8'h00 : rx_mem_r[rx_rd_ptr_r];
            2'b01:   rdata_s = status_s;
            default: rdata_s = 8'h00;
         endcase
      end else begin
         rdata_s = rdata_r;
      end
   end

   // Control state, pointers, flags and registered outputs.
   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         state_r     <= ST_IDLE;
         tx_wr_ptr_r <= PTR_ZERO;
         tx_rd_ptr_r <= PTR_ZERO;
         rx_wr_ptr_r <= PTR_ZERO;
         rx_rd_ptr_r <= PTR_ZERO;
         tx_cnt_r    <= CNT_ZERO;
         rx_cnt_r    <= CNT_ZERO;
         tx_drop_r   <= 1'b0;
         rx_ovr_r    <= 1'b0;
         ready_d_r   <= 1'b0;
         rdata_r     <= 8'h00;
         ack_r       <= 1'b0;
         irq_r       <= 1'b0;
         request_r   <= 1'b0;
         uart_data_r <= 8'h00;
      end else begin
         state_r   <= state_s;
         tx_cnt_r  <= tx_cnt_s;
         rx_cnt_r  <= rx_cnt_s;
         tx_drop_r <= tx_drop_s;
         rx_ovr_r  <= rx_ovr_s;
         ready_d_r <= s_uart_ready_i;
         rdata_r   <= rdata_s;
         ack_r     <= s_req_i;
         irq_r     <= (rx_cnt_s != CNT_ZERO) | rx_ovr_s;
         request_r <= (state_s == ST_ISSUE);
         if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + PTR_ONE;
         if (tx_pop_s) begin
            tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
            uart_data_r <= tx_mem_r[tx_rd_ptr_r];
         end
         if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
         if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
      end
   end

   // FIFO storage; contents are don't-care while the matching count is zero.
   always_ff @(posedge s_clk_i) begin
      if (tx_push_s) tx_mem_r[tx_wr_ptr_r] <= s_wdata_i;
      if (rx_push_s) rx_mem_r[rx_wr_ptr_r] <= s_uart_data_i;
   end

   assign s_rdata_o        = rdata_r;
   assign s_ack_o          = ack_r;
   assign s_irq_o          = irq_r;
   assign s_uart_request_o = request_r;
   assign s_uart_data_o    = uart_data_r;

endmodule
